clip_stream: RTL and testbench
==============================

// Module: clip_stream
// PURPOSE
//  Column-border clip for a raster pixel stream following a WIDTH_NB-wide sliding window.
//  The first WIDTH_NB-1 pixels of each row are invalid window results and get their valid masked.
//  Data passes through one register stage; only dn_val is masked.
//  Row length is runtime-configured; the row position persists across stream gaps.
// PARAMETERS
//  WIDTH_NB    3   window width; columns 0..WIDTH_NB-2 of each row are clipped
//  IMG_WIDTH   8   pixel data width (bits)
//  MEM_AWIDTH  8   width of cfg_delay and of the internal row counter
//  MEM_DEPTH   15  maximum supported row length (pixels)
// PORTS
//  clk        in   1           clock; all logic on rising edge
//  rst        in   1           synchronous, active-high reset
//  cfg_delay  in   MEM_AWIDTH  row length in pixels; sampled when cfg_set=1
//  cfg_set    in   1           load cfg_delay and restart the row position
//  up_data    in   IMG_WIDTH   input pixel
//  up_val     in   1           input pixel valid; no back-pressure
//  dn_data    out  IMG_WIDTH   output pixel
//  dn_val     out  1           output valid (up_val & row_mask, delayed 1 cycle)
// BEHAVIOUR
//  - Reset: dn_val=0, dn_data=0, row_cnt=0, row length register=0.
//  - Row length: cfg_set=1 loads min(cfg_delay, MEM_DEPTH) and clears row_cnt to 0.
//  - Pass-through: row length 0 (e.g. after reset), or any value < WIDTH_NB.
//    In this mode dn_val=up_val, delayed 1 cycle, and row_cnt stays 0.
//  - row_cnt (MEM_AWIDTH bits) is the column index of the current input pixel.
//    It increments on each up_val=1 cycle, wraps from len-1 to 0, and holds when up_val=0.
//  - row_mask = (row_cnt >= WIDTH_NB-1), evaluated combinationally on the current row_cnt.
//  - Output register, 1-cycle latency:
//    dn_val <= up_val & row_mask.
//    dn_data <= up_data when up_val=1; otherwise dn_data holds its value.
//  - Gaps in up_val do not affect row position; a row resumes at the held column.
//  - cfg_set together with up_val: cfg_set wins.
//    That pixel is column 0 under the new length: it is masked and row_cnt becomes 1.
//    The new length is used for the wrap from that cycle on.
//  - cfg_set mid-row abandons the partial row; no flush, and already-registered outputs still emit.
//  - rst mid-stream: the next-cycle outputs are 0 and the configuration is lost
//    (pass-through until the next cfg_set).
//  - No FSM; state is row length, row_cnt, and the output registers.
// TESTING
//  1. rst 6 cycles, no cfg, up 1..5 valid -> dn_val=1 for all, dn_data 1..5, each 1 cycle late.
//  2. cfg_delay=10/cfg_set, up 1..27 back-to-back -> valid out 3..10,13..20,23..27;
//     1,2,11,12,21,22 give dn_val=0.
//  3. Continue after 5-idle gap with 28..60 -> valid 28..30,33..40,43..50,53..60;
//     31,32,41,42,51,52 masked (row_cnt resumes at 7).
//  4. cfg_delay=20 -> length clamps to 15: pixels at columns 0,1 of each 15-pixel row are masked.
//  5. cfg_set=1 with up_val=1 mid-row (col 6), cfg_delay=10 -> that pixel is masked, the next is masked,
//     then 8 pass.
//  6. rst asserted mid-row -> dn_val=0 the next cycle; afterwards all pixels pass.

Source files
------------

// File: rtl/clip_stream.sv
// clip_stream: column-border clip for a raster pixel stream that follows a
// WIDTH_NB-wide sliding window. The first WIDTH_NB-1 pixels of every row are
// not valid window results, so their output valid is masked. Data passes
// through a single register stage and only dn_val is ever masked.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cfg_delay  row length in pixels, sampled when cfg_set=1 (clamped to MEM_DEPTH)
//   cfg_set    load cfg_delay and restart the row position at column 0
//   up_data    input pixel
//   up_val     input pixel valid (no back-pressure)
//   dn_data    registered pixel; holds when up_val=0
//   dn_val     registered up_val & row_mask
module clip_stream #(
  parameter int WIDTH_NB   = 3,
  parameter int IMG_WIDTH  = 8,
  parameter int MEM_AWIDTH = 8,
  parameter int MEM_DEPTH  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_AWIDTH-1:0] cfg_delay,
  input  logic                  cfg_set,
  input  logic [IMG_WIDTH-1:0]  up_data,
  input  logic                  up_val,
  output logic [IMG_WIDTH-1:0]  dn_data,
  output logic                  dn_val
);

  localparam logic [MEM_AWIDTH-1:0] DEPTH_C = MEM_AWIDTH'(MEM_DEPTH);
  localparam logic [MEM_AWIDTH-1:0] WNB_C   = MEM_AWIDTH'(WIDTH_NB);
  localparam logic [MEM_AWIDTH-1:0] FIRST_C = MEM_AWIDTH'(WIDTH_NB - 1);
  localparam logic [MEM_AWIDTH-1:0] ONE_C   = MEM_AWIDTH'(1);

  logic [MEM_AWIDTH-1:0] len_q, len_d;
  logic [MEM_AWIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [IMG_WIDTH-1:0]  dn_data_q, dn_data_d;
  logic                  dn_val_q, dn_val_d;

  logic [MEM_AWIDTH-1:0] len_cfg, eff_len, eff_cnt;
  logic                  pass_thru, row_mask, row_last;

  always_comb begin
    len_cfg = (cfg_delay > DEPTH_C) ? DEPTH_C : cfg_delay;
    // A cfg_set cycle already runs under the new length with the pixel at column 0.
    eff_len = cfg_set ? len_cfg : len_q;
    eff_cnt = cfg_set ? '0 : row_cnt_q;
    // Rows shorter than the window never produce a valid result column;
    // treat them (and the unconfigured length 0) as pass-through.
    pass_thru = (eff_len < WNB_C);
    row_mask  = pass_thru || (eff_cnt >= FIRST_C);
    // eff_len >= WIDTH_NB here whenever it matters, so the subtract cannot wrap.
    row_last  = (eff_cnt >= eff_len - ONE_C);

    len_d     = eff_len;
    row_cnt_d = eff_cnt;
    if (pass_thru)   row_cnt_d = '0;
    else if (up_val) row_cnt_d = row_last ? '0 : eff_cnt + ONE_C;

    dn_val_d  = up_val && row_mask;
    dn_data_d = up_val ? up_data : dn_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      row_cnt_q <= '0;
      dn_val_q  <= 1'b0;
      dn_data_q <= '0;
    end else begin
      len_q     <= len_d;
      row_cnt_q <= row_cnt_d;
      dn_val_q  <= dn_val_d;
      dn_data_q <= dn_data_d;
    end
  end

  assign dn_val  = dn_val_q;
  assign dn_data = dn_data_q;

endmodule

// File: tb/tb_clip_stream.sv
// Testbench for clip_stream: directed scenarios followed by random traffic,
// all checked every cycle against an integer row-position model.
module tb_clip_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_delay;
  logic       cfg_set;
  logic [7:0] up_data;
  logic       up_val;
  logic [7:0] dn_data;
  logic       dn_val;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int m_len = 0;
  int m_col = 0;
  bit exp_val = 1'b0;
  int exp_data = 0;

  always #5 clk = ~clk;

  clip_stream #(.WIDTH_NB(3), .IMG_WIDTH(8), .MEM_AWIDTH(8), .MEM_DEPTH(15)) dut (
    .clk(clk), .rst(rst), .cfg_delay(cfg_delay), .cfg_set(cfg_set),
    .up_data(up_data), .up_val(up_val), .dn_data(dn_data), .dn_val(dn_val)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model, check outputs just after the edge.
  task automatic step(input bit r, input bit cs, input int cd, input bit uv, input int ud);
    rst = r; cfg_set = cs; cfg_delay = 8'(cd); up_val = uv; up_data = 8'(ud);
    @(posedge clk);
    if (r) begin
      m_len = 0; m_col = 0; exp_val = 0; exp_data = 0;
    end else begin
      if (cs) begin
        m_len = (cd > 15) ? 15 : cd;
        m_col = 0;
      end
      if (uv) begin
        exp_val  = (m_len < 3) ? 1'b1 : (m_col >= 2);
        exp_data = ud;
        if (m_len >= 3) m_col = (m_col + 1) % m_len;
      end else begin
        exp_val = 1'b0;
      end
    end
    #1;
    chk("dn_val", 32'(dn_val), 32'(exp_val));
    chk("dn_data", 32'(dn_data), exp_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int vcount;
    rst = 1'b1; cfg_set = 1'b0; cfg_delay = '0; up_val = 1'b0; up_data = '0;

    // 1. reset then pass-through with no configuration
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
    chk("reset_val", 32'(dn_val), 0);
    chk("reset_data", 32'(dn_data), 0);
    for (int p = 1; p <= 5; p++) step(0, 0, 0, 1, p);

    // 2. row length 10, 27 back-to-back pixels
    step(0, 1, 10, 0, 0);
    vcount = 0;
    for (int p = 1; p <= 27; p++) begin
      step(0, 0, 0, 1, p);
      if (dn_val) vcount++;
    end
    chk("row10_valid_count", vcount, 21);

    // 3. gap, then resume mid-row at column 7
    idle(5);
    for (int p = 28; p <= 60; p++) step(0, 0, 0, 1, p);

    // 4. length clamps to 15
    step(0, 1, 20, 0, 0);
    vcount = 0;
    for (int p = 1; p <= 45; p++) begin
      step(0, 0, 0, 1, p);
      if (dn_val) vcount++;
    end
    chk("clamp15_valid_count", vcount, 39);

    // 5. cfg_set together with a pixel at column 6
    step(0, 1, 10, 0, 0);
    for (int p = 1; p <= 6; p++) step(0, 0, 0, 1, p);
    step(0, 1, 10, 1, 100);
    chk("cfg_with_pixel_masked", 32'(dn_val), 0);
    step(0, 0, 0, 1, 101);
    chk("col1_masked", 32'(dn_val), 0);
    for (int p = 102; p < 110; p++) begin
      step(0, 0, 0, 1, p);
      chk("post_cfg_pass", 32'(dn_val), 1);
    end

    // 6. reset mid-row, then pass-through
    for (int p = 1; p <= 4; p++) step(0, 0, 0, 1, p);
    step(1, 0, 0, 1, 77);
    chk("rst_midrow_val", 32'(dn_val), 0);
    chk("rst_midrow_data", 32'(dn_data), 0);
    for (int p = 1; p <= 5; p++) begin
      step(0, 0, 0, 1, p);
      chk("after_rst_pass", 32'(dn_val), 1);
    end

    // short lengths (below the window) and length equal to the window
    step(0, 1, 2, 1, 9);
    for (int p = 1; p <= 6; p++) step(0, 0, 0, 1, p);
    step(0, 1, 3, 0, 0);
    for (int p = 1; p <= 9; p++) step(0, 0, 0, 1, p);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, cs, uv;
      r  = ($urandom_range(0, 199) == 0);
      cs = ($urandom_range(0, 39) == 0);
      uv = ($urandom_range(0, 3) != 0);
      step(r, cs, $urandom_range(0, 25), uv, $urandom_range(0, 255));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
